// File: rtl/uart_io_unit.sv
// UART I/O buffer: RX/TX byte FIFOs between IN/OUT instructions and the uart_rx/uart_tx engines.
// Optional macro IO_COUNTERS_EN adds rx_drop_cnt / tx_sent_cnt statistics outputs.
module uart_io_unit #(
  parameter int unsigned RX_AW     = 11,
  parameter int unsigned TX_AW     = 14,
  parameter logic [7:0]  SYNC_BYTE = 8'hAA
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [2:0]  mode,
  input  logic        in_req,
  input  logic [1:0]  in_size,
  output logic [31:0] in_data,
  input  logic        out_req,
  input  logic [1:0]  out_size,
  input  logic [31:0] out_data,
  output logic        busy,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  output logic [7:0]  tx_byte,
  output logic        tx_start,
  input  logic        tx_busy,
  output logic        sync_sent,
  output logic        sync_recv,
  output logic        rx_overflow
`ifdef IO_COUNTERS_EN
  ,
  output logic [15:0] rx_drop_cnt,
  output logic [31:0] tx_sent_cnt
`endif
);

  localparam int unsigned RX_DEPTH = 1 << RX_AW;
  localparam int unsigned TX_DEPTH = 1 << TX_AW;

  typedef enum logic [1:0] {IDLE, IN_RUN, OUT_RUN} state_t;
  typedef enum logic [1:0] {SY_SEND, SY_RISE, SY_FALL, SY_DONE} sync_t;

  state_t      state, state_d;
  sync_t       sync_st, sync_st_d;
  logic [1:0]  cnt, cnt_d, last, last_d;
  logic [31:0] acc, acc_d, out_lat, out_lat_d, in_data_d;
  logic        sync_sent_d, tx_start_d, tx_start_q, tx_guard;
  logic [7:0]  tx_byte_d;

  logic [7:0]     rx_mem [RX_DEPTH];
  logic [RX_AW:0] rx_wr, rx_rd;
  logic           rx_empty, rx_full, rx_push, rx_pop, rx_drop;
  logic [7:0]     rx_head;

  logic [7:0]     tx_mem [TX_DEPTH];
  logic [TX_AW:0] tx_wr, tx_rd;
  logic           tx_empty, tx_full, tx_push, tx_pop;
  logic [7:0]     tx_head, tx_wdata;

  // Index of the final byte of a transfer: 1, 2 or 4 bytes.
  function automatic logic [1:0] last_idx(input logic [1:0] size);
    case (size)
      2'b00:   return 2'd0;
      2'b01:   return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

  // FIFO status; the extra pointer bit distinguishes full from empty.
  assign rx_empty = (rx_wr == rx_rd);
  assign rx_full  = (rx_wr[RX_AW-1:0] == rx_rd[RX_AW-1:0]) && (rx_wr[RX_AW] != rx_rd[RX_AW]);
  assign rx_head  = rx_mem[rx_rd[RX_AW-1:0]];
  assign rx_push  = (mode == 3'd2) && rx_valid && (!rx_full || rx_pop);
  assign rx_drop  = (mode == 3'd2) && rx_valid && rx_full && !rx_pop;

  assign tx_empty = (tx_wr == tx_rd);
  assign tx_full  = (tx_wr[TX_AW-1:0] == tx_rd[TX_AW-1:0]) && (tx_wr[TX_AW] != tx_rd[TX_AW]);
  assign tx_head  = tx_mem[tx_rd[TX_AW-1:0]];
  assign tx_wdata = out_lat[{cnt, 3'b000} +: 8];

  assign busy      = ((state == IDLE) && (in_req || out_req)) || (state != IDLE);
  assign sync_recv = rx_valid && (rx_byte == SYNC_BYTE);
  assign tx_guard  = !tx_start && !tx_start_q;

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr[RX_AW-1:0]] <= rx_byte;
    if (tx_push) tx_mem[tx_wr[TX_AW-1:0]] <= tx_wdata;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_d;
  end

  // Instruction FSM: IN assembles bytes from RX, OUT splits latched word into TX.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    last_d    = last;
    acc_d     = acc;
    out_lat_d = out_lat;
    in_data_d = in_data;
    rx_pop    = 1'b0;
    tx_push   = 1'b0;
    unique case (state)
      IDLE: begin
        if (in_req) begin
          state_d = IN_RUN;
          cnt_d   = 2'd0;
          last_d  = last_idx(in_size);
          acc_d   = '0;
        end else if (out_req) begin
          state_d   = OUT_RUN;
          cnt_d     = 2'd0;
          last_d    = last_idx(out_size);
          out_lat_d = out_data;
        end
      end
      IN_RUN: begin
        if (!rx_empty) begin
          rx_pop = 1'b1;
          acc_d[{cnt, 3'b000} +: 8] = rx_head;
          cnt_d = cnt + 2'd1;
          if (cnt == last) begin
            in_data_d = acc_d;
            state_d   = IDLE;
          end
        end
      end
      OUT_RUN: begin
        if (!tx_full) begin
          tx_push = 1'b1;
          cnt_d   = cnt + 2'd1;
          if (cnt == last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // TX side: sync handshake in LOAD mode, FIFO drain otherwise.
  always_comb begin
    sync_st_d   = sync_st;
    sync_sent_d = sync_sent;
    tx_start_d  = 1'b0;
    tx_byte_d   = tx_byte;
    tx_pop      = 1'b0;
    if (mode == 3'd1) begin
      unique case (sync_st)
        SY_SEND: if (!tx_busy && tx_guard) begin
          tx_start_d = 1'b1;
          tx_byte_d  = SYNC_BYTE;
          sync_st_d  = SY_RISE;
        end
        SY_RISE: if (tx_busy) sync_st_d = SY_FALL;
        SY_FALL: if (!tx_busy) begin
          sync_sent_d = 1'b1;
          sync_st_d   = SY_DONE;
        end
        default: sync_st_d = sync_st;
      endcase
    end else if (!tx_empty && !tx_busy && tx_guard) begin
      tx_pop     = 1'b1;
      tx_start_d = 1'b1;
      tx_byte_d  = tx_head;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_st     <= SY_SEND;
      cnt         <= 2'd0;
      last        <= 2'd0;
      acc         <= '0;
      out_lat     <= '0;
      in_data     <= '0;
      sync_sent   <= 1'b0;
      tx_start    <= 1'b0;
      tx_start_q  <= 1'b0;
      tx_byte     <= '0;
      rx_overflow <= 1'b0;
      rx_wr       <= '0;
      rx_rd       <= '0;
      tx_wr       <= '0;
      tx_rd       <= '0;
    end else begin
      sync_st    <= sync_st_d;
      cnt        <= cnt_d;
      last       <= last_d;
      acc        <= acc_d;
      out_lat    <= out_lat_d;
      in_data    <= in_data_d;
      sync_sent  <= sync_sent_d;
      tx_start   <= tx_start_d;
      tx_start_q <= tx_start;
      tx_byte    <= tx_byte_d;
      if (rx_drop) rx_overflow <= 1'b1;
      if (rx_push) rx_wr <= rx_wr + (RX_AW+1)'(1);
      if (rx_pop)  rx_rd <= rx_rd + (RX_AW+1)'(1);
      if (tx_push) tx_wr <= tx_wr + (TX_AW+1)'(1);
      if (tx_pop)  tx_rd <= tx_rd + (TX_AW+1)'(1);
    end
  end

`ifdef IO_COUNTERS_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_drop_cnt <= '0;
      tx_sent_cnt <= '0;
    end else begin
      if (rx_drop && (rx_drop_cnt != 16'hFFFF)) rx_drop_cnt <= rx_drop_cnt + 16'd1;
      if (tx_start_d) tx_sent_cnt <= tx_sent_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_uart_io_unit.sv
// Self-checking bench for uart_io_unit with small FIFOs (RX depth 4, TX depth 8) and a PHY model.
module tb_uart_io_unit;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [2:0]  mode = '0;
  logic        in_req = 1'b0;
  logic [1:0]  in_size = '0;
  logic [31:0] in_data;
  logic        out_req = 1'b0;
  logic [1:0]  out_size = '0;
  logic [31:0] out_data = '0;
  logic        busy;
  logic [7:0]  rx_byte = '0;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_byte;
  logic        tx_start;
  logic        tx_busy;
  logic        sync_sent, sync_recv, rx_overflow;

  always #5 clk = ~clk;

  uart_io_unit #(.RX_AW(2), .TX_AW(3), .SYNC_BYTE(8'hAA)) dut (
    .clk(clk), .rstn(rstn), .mode(mode),
    .in_req(in_req), .in_size(in_size), .in_data(in_data),
    .out_req(out_req), .out_size(out_size), .out_data(out_data),
    .busy(busy), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .tx_byte(tx_byte), .tx_start(tx_start), .tx_busy(tx_busy),
    .sync_sent(sync_sent), .sync_recv(sync_recv), .rx_overflow(rx_overflow)
  );

  int total = 0;
  int bad = 0;
  logic [7:0] rxq[$];
  logic [7:0] tx_log[$];
  logic [7:0] txe[$];
  int phy_cnt = 0;
  int start_viol = 0;

  // PHY model: each start pulse keeps tx_busy high for 10 cycles.
  assign tx_busy = (phy_cnt != 0);
  always @(posedge clk or negedge rstn) begin
    if (!rstn) phy_cnt <= 0;
    else if (tx_start) begin
      if (tx_busy) start_viol <= start_viol + 1;
      tx_log.push_back(tx_byte);
      phy_cnt <= 10;
    end else if (phy_cnt != 0) phy_cnt <= phy_cnt - 1;
  end

  typedef struct {
    int unsigned n_push;
    logic [31:0] bytes;
    logic [1:0]  size;
    logic [31:0] exp_data;
    int          exp_busy;
  } in_vec_t;
  in_vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
  endfunction

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic push_rx(input logic [7:0] b);
    rx_valid = 1'b1; rx_byte = b; rxq.push_back(b);
    cyc();
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int bound);
    bit tmo;
    tmo = 1'b1;
    for (int c = 0; c < bound; c++) begin
      @(negedge clk);
      if (!busy) begin tmo = 1'b0; break; end
      cyc();
    end
    chk(name, 32'(tmo), 32'd0);
    cyc();
  endtask

  task automatic wait_tx(input int target);
    bit tmo;
    tmo = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      if (tx_log.size() >= target) begin tmo = 1'b0; break; end
      cyc();
    end
    chk("tx_wait_timeout", 32'(tmo), 32'd0);
  endtask

  // Issue one IN; optionally feed missing bytes at random gaps while it waits.
  task automatic run_in(input logic [1:0] sz, input bit feed, output int bc, output bit tmo);
    int n;
    n = nbytes(sz);
    bc = 0; tmo = 1'b1;
    in_size = sz; in_req = 1'b1;
    for (int c = 0; c < 400; c++) begin
      if (feed && rxq.size() < n && $urandom_range(2) == 0) begin
        rx_valid = 1'b1; rx_byte = 8'($urandom); rxq.push_back(rx_byte);
      end else rx_valid = 1'b0;
      @(negedge clk);
      if (!busy) begin tmo = 1'b0; break; end
      bc++;
      cyc();
      in_req = 1'b0;
    end
    cyc();
    in_req = 1'b0; rx_valid = 1'b0;
  endtask

  task automatic run_out(input logic [31:0] d, input logic [1:0] sz);
    out_data = d; out_size = sz; out_req = 1'b1;
    cyc();
    out_req = 1'b0;
    wait_idle("out_idle_timeout", 600);
    for (int k = 0; k < nbytes(sz); k++) txe.push_back(d[8*k +: 8]);
  endtask

  function automatic logic [31:0] take_rx(input int n);
    logic [31:0] v;
    v = '0;
    for (int j = 0; j < n; j++) v = v | (32'(rxq.pop_front()) << (8 * j));
    return v;
  endfunction

  initial begin
    int bc, n, k, pre, base;
    bit tmo, ok, seen, early;
    logic [1:0] sz;
    logic [31:0] d, expv;

    vecs[0] = '{4, 32'h44332211, 2'b10, 32'h44332211, 5};
    vecs[1] = '{1, 32'h000000AB, 2'b00, 32'h000000AB, 2};
    vecs[2] = '{2, 32'h00008001, 2'b01, 32'h00008001, 3};
    vecs[3] = '{4, 32'h98BADCFE, 2'b11, 32'h98BADCFE, 5};
    vecs[4] = '{2, 32'h0000C35A, 2'b00, 32'h0000005A, 2};
    vecs[5] = '{1, 32'h0000003C, 2'b01, 32'h00003CC3, 3};

    repeat (3) cyc();
    chk("rst_in_data", in_data, 32'h0);
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_tx_byte", 32'(tx_byte), 32'h0);
    chk("rst_sync_sent", 32'(sync_sent), 32'd0);
    chk("rst_rx_overflow", 32'(rx_overflow), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rstn = 1'b1;
    cyc();

    // LOAD: a single sync byte, sync_sent only after the PHY goes idle again.
    mode = 3'd1; seen = 1'b0; early = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (tx_busy) seen = 1'b1;
      if (tx_busy && sync_sent) early = 1'b1;
      cyc();
    end
    chk("sync_count", 32'(tx_log.size()), 32'd1);
    chk("sync_byte", 32'(tx_log[0]), 32'hAA);
    chk("sync_sent", 32'(sync_sent), 32'd1);
    chk("sync_busy_seen", 32'(seen), 32'd1);
    chk("sync_sent_early", 32'(early), 32'd0);
    rx_valid = 1'b1; rx_byte = 8'hAA; #1;
    chk("sync_recv_hit", 32'(sync_recv), 32'd1);
    rx_byte = 8'h55; #1;
    chk("sync_recv_miss", 32'(sync_recv), 32'd0);
    rx_valid = 1'b0;
    cyc();

    // TX FIFO holds in LOAD mode and drains once EXEC is selected.
    run_out(32'h0000005C, 2'b00);
    repeat (30) cyc();
    chk("load_no_drain", 32'(tx_log.size()), 32'd1);
    mode = 3'd2;
    wait_tx(2);
    chk("exec_drain", 32'(tx_log[1]), 32'h5C);
    txe.delete();

    for (int i = 0; i < 6; i++) begin
      for (int b = 0; b < int'(vecs[i].n_push); b++) push_rx(vecs[i].bytes[8*b +: 8]);
      run_in(vecs[i].size, 1'b0, bc, tmo);
      chk($sformatf("vec%0d_data", i), in_data, vecs[i].exp_data);
      chk($sformatf("vec%0d_busy", i), 32'(bc), 32'(vecs[i].exp_busy));
      chk($sformatf("vec%0d_tmo", i), 32'(tmo), 32'd0);
      void'(take_rx(nbytes(vecs[i].size)));
    end

    // IN on an empty FIFO stalls until the byte arrives.
    in_size = 2'b00; in_req = 1'b1; ok = 1'b1;
    @(negedge clk); if (!busy) ok = 1'b0;
    cyc(); in_req = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk); if (!busy) ok = 1'b0;
      cyc();
    end
    chk("empty_in_busy", 32'(ok), 32'd1);
    push_rx(8'h7F);
    wait_idle("empty_in_timeout", 10);
    chk("empty_in_data", in_data, 32'h0000007F);
    void'(take_rx(1));

    base = tx_log.size();
    run_out(32'hDEADBEEF, 2'b01);
    wait_tx(base + 2);
    chk("out_b0", 32'(tx_log[base]), 32'hEF);
    chk("out_b1", 32'(tx_log[base + 1]), 32'hBE);
    txe.delete();

    // Randomised IN/OUT mix against the queue model.
    base = tx_log.size();
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(1) == 0) begin
        sz = 2'($urandom_range(3)); n = nbytes(sz);
        k = $urandom_range(4 - rxq.size());
        pre = rxq.size() + k;
        repeat (k) push_rx(8'($urandom));
        run_in(sz, 1'b1, bc, tmo);
        expv = take_rx(n);
        chk("rnd_in_data", in_data, expv);
        chk("rnd_in_tmo", 32'(tmo), 32'd0);
        if (pre >= n) chk("rnd_in_busy", 32'(bc), 32'(n + 1));
      end else begin
        d = $urandom; sz = 2'($urandom_range(3));
        run_out(d, sz);
      end
    end
    wait_tx(base + txe.size());
    for (int i = 0; i < txe.size(); i++) chk("rnd_tx_byte", 32'(tx_log[base + i]), 32'(txe[i]));
    while (rxq.size() > 0) begin
      expv = 32'(rxq[0]);
      run_in(2'b00, 1'b0, bc, tmo);
      void'(take_rx(1));
      chk("rnd_leftover", in_data, expv);
    end

    // Overflow: fifth byte into a 4-deep FIFO is dropped.
    for (int i = 0; i < 4; i++) push_rx(8'(8'hA1 + i));
    chk("ovf_before", 32'(rx_overflow), 32'd0);
    rx_valid = 1'b1; rx_byte = 8'hA5;
    cyc();
    rx_valid = 1'b0;
    chk("ovf_after", 32'(rx_overflow), 32'd1);
    run_in(2'b10, 1'b0, bc, tmo);
    chk("ovf_in_data", in_data, 32'hA4A3A2A1);
    void'(take_rx(4));

    // Simultaneous IN and OUT: IN completes first, OUT taken on the next IDLE cycle.
    push_rx(8'h6E);
    base = tx_log.size();
    in_size = 2'b00; in_req = 1'b1;
    out_data = 32'h000000C7; out_size = 2'b00; out_req = 1'b1;
    @(negedge clk); chk("both_busy0", 32'(busy), 32'd1);
    cyc(); in_req = 1'b0;
    @(negedge clk); chk("both_busy1", 32'(busy), 32'd1);
    cyc();
    @(negedge clk); chk("both_busy2", 32'(busy), 32'd1);
    chk("both_in_first", in_data, 32'h0000006E);
    cyc(); out_req = 1'b0;
    @(negedge clk); chk("both_busy3", 32'(busy), 32'd1);
    cyc();
    @(negedge clk); chk("both_busy4", 32'(busy), 32'd0);
    cyc();
    void'(take_rx(1));
    wait_tx(base + 1);
    chk("both_out_byte", 32'(tx_log[base]), 32'hC7);

    // Reset in the middle of an IN discards both FIFOs.
    push_rx(8'h99);
    mode = 3'd1;
    run_out(32'h0BADF00D, 2'b10);
    base = tx_log.size();
    in_size = 2'b10; in_req = 1'b1;
    cyc(); in_req = 1'b0;
    cyc(); cyc();
    rstn = 1'b0; mode = 3'd0; #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_in_data", in_data, 32'h0);
    chk("mid_rst_sync_sent", 32'(sync_sent), 32'd0);
    chk("mid_rst_overflow", 32'(rx_overflow), 32'd0);
    cyc();
    mode = 3'd2; rstn = 1'b1;
    repeat (60) cyc();
    chk("mid_rst_tx_empty", 32'(tx_log.size()), 32'(base));
    rxq.delete();
    push_rx(8'h12); push_rx(8'h34);
    run_in(2'b01, 1'b0, bc, tmo);
    chk("mid_rst_rx_empty", in_data, 32'h00003412);
    chk("phy_start_while_busy", 32'(start_viol), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_io_unit.md
Name: uart_io_unit

Overview:
Parametrised UART I/O buffer for the execute stage. Decouples IN/OUT instructions from the uart_rx/uart_tx bit engines through RX and TX FIFOs. Supports variable transfer width (1, 2 or 4 bytes per instruction, little-endian) and the loader sync-byte handshake. Sits between the execute datapath and the uart_rx/uart_tx instances. Exposes a combinational busy signal that the pipeline uses as a stall.

Parameters:
RX_AW, 11, log2 of RX FIFO depth (2048 bytes)
TX_AW, 14, log2 of TX FIFO depth (16384 bytes)
SYNC_BYTE, 8'hAA, loader sync byte; sent in LOAD mode and detected on RX

Ports:
clk  in  1  system clock
rstn  in  1  reset, asynchronous, active-low
mode  in  3  1=LOAD, 2=EXEC, other=idle
in_req  in  1  IN instruction issue (start && !hazard)
in_size  in  2  00=1B, 01=2B, 10/11=4B
in_data  out  32  assembled IN result, zero-extended
out_req  in  1  OUT instruction issue
out_size  in  2  encoding as in_size
out_data  in  32  OUT source; bytes sent LSB first
busy  out  1  stall request to pipeline
rx_byte  in  8  from uart_rx
rx_valid  in  1  uart_rx ready pulse
tx_byte  out  8  to uart_tx
tx_start  out  1  one-cycle start pulse to uart_tx
tx_busy  in  1  from uart_tx
sync_sent  out  1  sticky; SYNC_BYTE transmitted
sync_recv  out  1  comb pulse: rx_valid && rx_byte==SYNC_BYTE
rx_overflow  out  1  sticky; an RX byte was dropped

Behaviour:
- Reset (async, rstn low): FIFO pointers 0, FSM IDLE, in_data=0, tx_byte=0, tx_start=0, sync_sent=0, rx_overflow=0. A reset in mid-operation aborts the transfer and discards the FIFO contents.
- FIFOs: register/BRAM storage with first-word-fall-through reads.
  - Pointers are RX_AW+1 / TX_AW+1 bits wide; the extra bit is the wrap bit.
  - empty = pointers equal. full = address bits equal and wrap bits differ.
  - Push and pop in the same cycle are legal in every state, including full and empty.
- RX push: when mode==2 && rx_valid. If the FIFO is full, the byte is dropped and rx_overflow is set. Bytes received outside EXEC mode are ignored.
- FSM states: IDLE, IN_RUN, OUT_RUN.
- IDLE:
  - in_req -> IN_RUN, byte count=0, accumulator=0.
  - Otherwise out_req -> OUT_RUN, out_data is latched.
  - in_req has priority. The caller holds out_req until it is accepted.
- IN_RUN: pops one byte per cycle while the RX FIFO is non-empty. Byte k is written to acc[8k+7:8k]. On the last byte, in_data is loaded with the full accumulator (upper bytes 0) in the same edge, and the FSM returns to IDLE. Latency with data already queued is N+1 cycles from in_req.
- OUT_RUN: pushes latched byte k per cycle while the TX FIFO is not full, stalling while full. After N pushes the FSM returns to IDLE.
- busy = (state==IDLE && (in_req||out_req)) || state!=IDLE.
- TX drain (mode!=1):
  - Condition: TX FIFO non-empty, !tx_busy, and no tx_start in either of the previous 2 cycles (guard for the PHY busy rise).
  - Action: tx_byte <= head, tx_start pulses for 1 cycle, pop.
- LOAD mode (mode==1):
  - While sync_sent==0: issue tx_start with tx_byte=SYNC_BYTE once, then wait for tx_busy to rise and fall, then set sync_sent.
  - The TX FIFO does not drain in LOAD mode.
  - sync_sent is cleared only by reset.

Optional Feature:
IO_COUNTERS_EN:
- Defined: adds outputs rx_drop_cnt[15:0] (saturating count of dropped RX bytes) and tx_sent_cnt[31:0] (wrapping count of tx_start pulses, including the sync byte). Both reset to 0.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then mode=1 with tx_busy modelled high for 10 cycles after the start pulse -> exactly one tx_start with tx_byte=8'hAA; sync_sent=1 after tx_busy falls; no further pulses.
- mode=2: push rx bytes 0x11,0x22,0x33,0x44, then in_req with in_size=10 -> in_data=32'h44332211; busy high for exactly 5 cycles.
- in_req with in_size=00 on an empty RX FIFO; send 0x7F after 50 cycles -> busy stays high throughout, then in_data=32'h0000007F.
- out_req with out_size=01, out_data=32'hDEADBEEF -> tx_byte sequence 0xEF, 0xBE; tx_start never pulses while tx_busy=1.
- RX_AW=2: push 5 bytes with no pops -> rx_overflow=1; subsequent IN reads return the first 4 bytes in order.
- in_req and out_req asserted together -> IN is serviced first, OUT is accepted on the following IDLE cycle; assert rstn=0 mid-IN -> FSM IDLE, busy=0, FIFOs empty.
